// File: rtl/axi_rd_burst_mngr.sv
// axi_rd_burst_mngr
// Read-channel master for a single requester (e.g. the data cache). A start
// pulse requests the read arbiter, issues one AR transfer for a 16-byte-aligned
// address, collects a 4-beat 32-bit R burst with a matching ID and packs it
// into a 128-bit line. The line is returned with a one-cycle valid strobe, and
// a one-cycle finish pulse releases the arbiter.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_rq / gnt_rq            arbiter request / grant
//   arvalid/arready/arid/araddr  AR channel
//   rvalid/rready/rid/rdata/rlast R channel
//   rstart_rq, rin_addr        start pulse and address from the requester
//   rnext_rq, rnext_id         ID-consumed pulse and internal ID counter
//   next_rid                   ID to drive on the next AR
//   rdat_m_data/rdat_m_valid   assembled line and its one-cycle strobe
//   finish_mrd                 end-of-transaction pulse to the arbiter
//
// Optional feature (macro RDMNGR_RLAST_TERM_EN): the burst also ends on the
// first accepted beat carrying rlast; words not yet filled are zeroed.
module axi_rd_burst_mngr #(
  parameter logic [3:0] ID_RST = 4'd0,
  parameter int         BEATS  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         req_rq,
  input  logic         gnt_rq,
  output logic         arvalid,
  input  logic         arready,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  input  logic         rvalid,
  output logic         rready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rstart_rq,
  input  logic [31:0]  rin_addr,
  output logic         rnext_rq,
  output logic [3:0]   rnext_id,
  input  logic [3:0]   next_rid,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd
);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q;
  logic [3:0]             arid_q;
  logic [3:0]             id_cnt_q;
  logic [1:0]             beat_q;
  logic [BEATS-1:0][31:0] data_q;

  logic ar_hs, beat_acc, beat_last;

  assign ar_hs    = (state_q == ADDR) && arready;
  // Beats tagged with a foreign ID are still handshaken (rready is high) but dropped.
  assign beat_acc = (state_q == DATA) && rvalid && (rid == arid_q);

`ifdef RDMNGR_RLAST_TERM_EN
  assign beat_last = beat_acc && ((beat_q == 2'(BEATS-1)) || rlast);
`else
  assign beat_last = beat_acc && (beat_q == 2'(BEATS-1));
  logic unused_rlast;
  assign unused_rlast = rlast;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_rq       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    rdat_m_valid = 1'b0;
    finish_mrd   = 1'b0;
    unique case (state_q)
      IDLE: if (rstart_rq) state_d = REQ;
      REQ: begin
        req_rq = 1'b1;
        if (gnt_rq) state_d = ADDR;
      end
      ADDR: begin
        req_rq  = 1'b1;
        arvalid = 1'b1;
        if (arready) state_d = DATA;
      end
      DATA: begin
        req_rq = 1'b1;
        rready = 1'b1;
        if (beat_last) state_d = DONE;
      end
      DONE: begin
        rdat_m_valid = 1'b1;
        finish_mrd   = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      arid_q   <= '0;
      id_cnt_q <= ID_RST;
      beat_q   <= '0;
      data_q   <= '0;
    end else begin
      if (state_q == IDLE && rstart_rq) addr_q <= {rin_addr[31:4], 4'b0};
      if (state_q == REQ && gnt_rq)     arid_q <= next_rid;
      if (ar_hs) begin
        id_cnt_q <= id_cnt_q + 4'd1;
        beat_q   <= '0;
      end else if (beat_acc) begin
        beat_q <= beat_q + 2'd1;
      end
      for (int k = 0; k < BEATS; k++) begin
        if (beat_acc && beat_q == 2'(k)) data_q[k] <= rdata;
`ifdef RDMNGR_RLAST_TERM_EN
        // Early termination: clear the words the short burst never reaches.
        else if (beat_acc && rlast && 2'(k) > beat_q) data_q[k] <= '0;
`endif
      end
    end
  end

  assign araddr      = addr_q;
  assign arid        = arid_q;
  assign rnext_rq    = ar_hs;
  assign rnext_id    = id_cnt_q;
  assign rdat_m_data = data_q;

endmodule

// File: tb/tb_axi_rd_burst_mngr.sv
module tb_axi_rd_burst_mngr;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_rq, gnt_rq = 1'b0;
  logic         arvalid, arready = 1'b0;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic         rvalid = 1'b0, rready;
  logic [3:0]   rid = '0;
  logic [31:0]  rdata = '0;
  logic         rlast = 1'b0;
  logic         rstart_rq = 1'b0;
  logic [31:0]  rin_addr = '0;
  logic         rnext_rq;
  logic [3:0]   rnext_id;
  logic [3:0]   next_rid = '0;
  logic [127:0] rdat_m_data;
  logic         rdat_m_valid, finish_mrd;

  axi_rd_burst_mngr dut (
    .clk(clk), .rst_n(rst_n), .req_rq(req_rq), .gnt_rq(gnt_rq),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rlast(rlast),
    .rstart_rq(rstart_rq), .rin_addr(rin_addr), .rnext_rq(rnext_rq),
    .rnext_id(rnext_id), .next_rid(next_rid), .rdat_m_data(rdat_m_data),
    .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Pulse counters and captures, sampled mid-low-phase after inputs settle.
  int           nrq_cnt = 0, vld_cnt = 0, fin_cnt = 0;
  logic [31:0]  cap_addr = '0;
  logic [3:0]   cap_id = '0;
  logic [127:0] cap_line = '0;
  logic         req_at_done = 1'b0;

  always @(negedge clk) begin
    #2;
    if (rnext_rq) nrq_cnt++;
    if (arvalid && arready) begin cap_addr = araddr; cap_id = arid; end
    if (rdat_m_valid) begin vld_cnt++; cap_line = rdat_m_data; req_at_done = req_rq; end
    if (finish_mrd) fin_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // R-beat script
  logic [31:0] bt_data [8];
  logic [3:0]  bt_id   [8];
  int          bt_gap  [8];
  logic        bt_last [8];

  task automatic set_beat(input int i, input logic [31:0] d, input logic [3:0] id,
                          input int gap, input logic last);
    bt_data[i] = d; bt_id[i] = id; bt_gap[i] = gap; bt_last[i] = last;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; gnt_rq = 0; arready = 0; rvalid = 0; rlast = 0; rstart_rq = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start pulse, one-cycle grant; returns at the first negedge in ADDR.
  task automatic start_ar(input logic [31:0] addr, input logic [3:0] id);
    @(negedge clk);
    rstart_rq = 1'b1; rin_addr = addr;
    @(negedge clk);
    rstart_rq = 1'b0; gnt_rq = 1'b1; next_rid = id;
    @(negedge clk);
    gnt_rq = 1'b0; arready = 1'b0;
  endtask

  // Hold arready low for 'stall' cycles then handshake; returns in DATA.
  task automatic ar_hs(input int stall);
    repeat (stall) @(negedge clk);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic send_beats(input int nb);
    for (int i = 0; i < nb; i++) begin
      rvalid = 1'b0;
      repeat (bt_gap[i]) @(negedge clk);
      rvalid = 1'b1; rdata = bt_data[i]; rid = bt_id[i]; rlast = bt_last[i];
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  // lat = cycles after the last driven beat until rdat_m_valid (0 = next cycle).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rdat_m_valid) begin lat = i; break; end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout: rdat_m_valid never seen within 10 cycles");
    end
    @(negedge clk);
    #3;
  endtask

  task automatic txn(input logic [31:0] addr, input logic [3:0] id, input int nb, output int lat);
    start_ar(addr, id);
    ar_hs(0);
    send_beats(nb);
    wait_done(lat);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_rq, arvalid, rready, rnext_rq, rdat_m_valid, finish_mrd, arid, araddr, rnext_id} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: req=%b arv=%b rrdy=%b nrq=%b vld=%b fin=%b arid=%h araddr=%h nid=%h, want all 0",
               req_rq, arvalid, rready, rnext_rq, rdat_m_valid, finish_mrd, arid, araddr, rnext_id);
    end
    checks++;
    if (rdat_m_data !== '0) begin
      failures++; $display("FAIL reset_data: got %h want 0", rdat_m_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, n0, v0, f0;
    n0 = nrq_cnt; v0 = vld_cnt; f0 = fin_cnt;
    set_beat(0, 32'h11111111, 4'h3, 0, 1'b0);
    set_beat(1, 32'h22222222, 4'h3, 0, 1'b0);
    set_beat(2, 32'h33333333, 4'h3, 0, 1'b0);
    set_beat(3, 32'h44444444, 4'h3, 0, 1'b1);
    txn(32'hdeadbeef, 4'h3, 4, lat);
    checks++; if (cap_addr !== 32'hdeadbee0) begin failures++; $display("FAIL basic_araddr: got %h want deadbee0", cap_addr); end
    checks++; if (cap_id !== 4'h3) begin failures++; $display("FAIL basic_arid: got %h want 3", cap_id); end
    checks++; if (cap_line !== 128'h44444444_33333333_22222222_11111111) begin
      failures++; $display("FAIL basic_line: got %h want 44444444333333332222222211111111", cap_line); end
    checks++; if (vld_cnt - v0 !== 1) begin failures++; $display("FAIL basic_vld_pulses: got %0d want 1", vld_cnt - v0); end
    checks++; if (fin_cnt - f0 !== 1) begin failures++; $display("FAIL basic_fin_pulses: got %0d want 1", fin_cnt - f0); end
    checks++; if (req_at_done !== 1'b0) begin failures++; $display("FAIL basic_req_in_done: got %b want 0", req_at_done); end
    checks++; if (req_rq !== 1'b0) begin failures++; $display("FAIL basic_req_after: got %b want 0", req_rq); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL basic_done_latency: got %0d want 0", lat); end
    checks++; if (nrq_cnt - n0 !== 1 || rnext_id !== 4'h1) begin
      failures++; $display("FAIL basic_next_id: pulses=%0d id=%h want 1/1", nrq_cnt - n0, rnext_id); end
  endtask

  task automatic test_ar_stall();
    int lat, n0;
    do_reset();
    n0 = nrq_cnt;
    start_ar(32'h1000_0004, 4'h9);
    next_rid = 4'h2;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin rstart_rq = 1'b1; rin_addr = 32'hffff_fff0; end
      else rstart_rq = 1'b0;
      #1;
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h1000_0000 || arid !== 4'h9 || rnext_rq !== 1'b0 || req_rq !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: arv=%b addr=%h id=%h nrq=%b req=%b want 1/10000000/9/0/1",
                 i, arvalid, araddr, arid, rnext_rq, req_rq);
      end
      @(negedge clk);
    end
    rstart_rq = 1'b0;
    arready = 1'b1;
    #1;
    checks++; if (rnext_rq !== 1'b1 || rnext_id !== 4'h0) begin
      failures++; $display("FAIL stall_hs: nrq=%b id=%h want 1/0", rnext_rq, rnext_id); end
    @(negedge clk);
    arready = 1'b0;
    #1;
    checks++; if (rnext_rq !== 1'b0 || rnext_id !== 4'h1 || arvalid !== 1'b0 || rready !== 1'b1) begin
      failures++; $display("FAIL stall_post: nrq=%b id=%h arv=%b rrdy=%b want 0/1/0/1", rnext_rq, rnext_id, arvalid, rready); end
    for (int i = 0; i < 4; i++) set_beat(i, 32'h0101_0101 * (i + 1), 4'h9, 0, i == 3);
    send_beats(4);
    wait_done(lat);
    checks++; if (cap_line !== 128'h04040404_03030303_02020202_01010101 || nrq_cnt - n0 !== 1) begin
      failures++; $display("FAIL stall_line: got %h pulses=%0d want 04040404030303030202020201010101/1", cap_line, nrq_cnt - n0); end
  endtask

  task automatic test_interleave();
    int lat;
    set_beat(0, 32'hA1A1A1A1, 4'h3, 0, 1'b0);
    set_beat(1, 32'h55555555, 4'h5, 0, 1'b0);
    set_beat(2, 32'hB2B2B2B2, 4'h3, 2, 1'b0);
    set_beat(3, 32'hC3C3C3C3, 4'h3, 1, 1'b0);
    set_beat(4, 32'hD4D4D4D4, 4'h3, 0, 1'b1);
    txn(32'h0000_1234, 4'h3, 5, lat);
    checks++; if (cap_line !== 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1) begin
      failures++; $display("FAIL interleave_line: got %h want D4D4D4D4C3C3C3C3B2B2B2B2A1A1A1A1", cap_line); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL interleave_latency: got %0d want 0", lat); end
  endtask

  task automatic test_rlast();
    int lat;
    set_beat(0, 32'h10101010, 4'h6, 0, 1'b0);
    set_beat(1, 32'h20202020, 4'h6, 0, 1'b1);
    set_beat(2, 32'h30303030, 4'h6, 0, 1'b0);
    set_beat(3, 32'h40404040, 4'h6, 0, 1'b1);
`ifdef RDMNGR_RLAST_TERM_EN
    txn(32'h0000_2000, 4'h6, 2, lat);
    checks++; if (cap_line !== {64'h0, 32'h20202020, 32'h10101010}) begin
      failures++; $display("FAIL rlast_line: got %h want 00000000000000002020202010101010", cap_line); end
`else
    txn(32'h0000_2000, 4'h6, 4, lat);
    checks++; if (cap_line !== 128'h40404040_30303030_20202020_10101010) begin
      failures++; $display("FAIL rlast_ignored_line: got %h want 40404040303030302020202010101010", cap_line); end
`endif
    checks++; if (lat !== 0) begin failures++; $display("FAIL rlast_latency: got %0d want 0", lat); end
  endtask

  task automatic test_id_wrap();
    int lat, n0;
    do_reset();
    n0 = nrq_cnt;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 4; i++) set_beat(i, {t[7:0], 24'h0} | 32'(i), 4'(t), 0, i == 3);
      txn(32'(t) << 4, 4'(t), 4, lat);
      if (t == 14) begin
        checks++; if (rnext_id !== 4'hF) begin failures++; $display("FAIL wrap_id15: got %h want f", rnext_id); end
      end
    end
    checks++; if (rnext_id !== 4'h0) begin failures++; $display("FAIL wrap_id0: got %h want 0", rnext_id); end
    checks++; if (nrq_cnt - n0 !== 16) begin failures++; $display("FAIL wrap_pulses: got %0d want 16", nrq_cnt - n0); end
    checks++; if (cap_line !== 128'h0F000003_0F000002_0F000001_0F000000) begin
      failures++; $display("FAIL wrap_last_line: got %h want 0f0000030f0000020f0000010f000000", cap_line); end
  endtask

  task automatic test_reset_mid();
    int lat, f0, v0;
    start_ar(32'h2000_001c, 4'h7);
    ar_hs(0);
    set_beat(0, 32'hE0E0E0E0, 4'h7, 0, 1'b0);
    set_beat(1, 32'hE1E1E1E1, 4'h7, 0, 1'b0);
    send_beats(2);
    f0 = fin_cnt; v0 = vld_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_rq, arvalid, rready, rnext_rq, rdat_m_valid, finish_mrd, arid, araddr, rnext_id} !== '0) begin
      failures++;
      $display("FAIL midrst_ctrl: req=%b arv=%b rrdy=%b arid=%h araddr=%h nid=%h want all 0",
               req_rq, arvalid, rready, arid, araddr, rnext_id);
    end
    checks++; if (rdat_m_data !== '0) begin failures++; $display("FAIL midrst_data: got %h want 0", rdat_m_data); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checks++; if (fin_cnt != f0 || vld_cnt != v0) begin
      failures++; $display("FAIL midrst_no_finish: fin=%0d vld=%0d extra pulses, want 0", fin_cnt - f0, vld_cnt - v0); end
    for (int i = 0; i < 4; i++) set_beat(i, 32'hF0F0F0F0 + 32'(i), 4'h7, 0, i == 3);
    txn(32'h2000_001c, 4'h7, 4, lat);
    checks++; if (cap_line !== 128'hF0F0F0F3_F0F0F0F2_F0F0F0F1_F0F0F0F0 || cap_addr !== 32'h2000_0010 || fin_cnt - f0 !== 1) begin
      failures++; $display("FAIL midrst_recover: line=%h addr=%h fin=%0d want f0f0f0f3f0f0f0f2f0f0f0f1f0f0f0f0/20000010/1",
                           cap_line, cap_addr, fin_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_interleave();
    test_rlast();
    test_id_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
